por_reset_sequencer: RTL and testbench
======================================

POR_RESET_SEQUENCER -- requirements
Module: por_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for asynchronous inputs (legal 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept an ext_resetb change (legal 1..15).
REQ-003 SHALL have parameter STRETCH_CYCLES, default 16: hold time after inputs go good, before core release (legal 1..256).
REQ-004 SHALL have parameter STAGGER_CYCLES, default 8: delay from core release to user release (legal 1..256).
REQ-005 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-007 SHALL have port porb_l, input, 1: asynchronous power-on-good from the POR block (1 = power good).
REQ-008 SHALL have port ext_resetb, input, 1: asynchronous active-low external pad reset.
REQ-009 SHALL have port core_resetb, output, 1: active-low reset to the management core.
REQ-010 SHALL have port user_reset, output, 1: active-high reset to the user project area.
REQ-011 SHALL have port por_done, output, 1: sticky flag, set on the first entry to RUN.
REQ-012 SHALL have port rst_cause, output, 2: cause of the last sequence restart (00 none, 01 POR, 10 external, 11 both).
REQ-013 SHALL have port ext_rst_count, output, 8: saturating count of accepted external reset assertions.

Function
REQ-014 SHALL synchronize porb_l through SYNC_STAGES flops (reset value 0) to produce porb_s.
REQ-015 SHALL synchronize ext_resetb through SYNC_STAGES flops (reset value 1), then filter it to ext_f (reset 1).
REQ-016 ext_f SHALL change only after the synchronized value differs from ext_f for DEBOUNCE_CYCLES consecutive cycles; any shorter pulse is discarded and the filter counter clears.
REQ-017 ok SHALL equal porb_s AND ext_f (combinational).
REQ-018 SHALL implement FSM states WAIT, STRETCH, CORE and RUN, plus an 8-bit counter cnt.
REQ-019 WAIT: on ok=1, SHALL go to STRETCH with cnt=0; otherwise SHALL stay in WAIT.
REQ-020 STRETCH: on ok=0, SHALL go to WAIT; else at cnt==STRETCH_CYCLES-1 SHALL go to CORE with cnt=0; else cnt+1.
REQ-021 CORE: on ok=0, SHALL go to WAIT; else at cnt==STAGGER_CYCLES-1 SHALL go to RUN; else cnt+1.
REQ-022 RUN: on ok=0, SHALL go to WAIT; otherwise SHALL stay in RUN.
REQ-023 Outputs SHALL be decoded from the state register with no added latency: core_resetb=1 in CORE and RUN only; user_reset=0 in RUN only.
REQ-024 ok=0 SHALL take priority over every counter terminal condition in the same cycle.
REQ-025 On any STRETCH/CORE/RUN->WAIT transition, rst_cause SHALL be loaded {~ext_f, ~porb_s}; on WAIT-state entry from reset it SHALL be 00.
REQ-026 ext_rst_count SHALL increment by one on each ext_f 1->0 transition, saturate at 255 and never wrap.
REQ-027 por_done SHALL be set on the first cycle state==RUN and remain 1 until reset.
REQ-028 Nominal release latency, counted from the first edge sampling porb_l=1 with ext_f=1: core_resetb rises SYNC_STAGES+1+STRETCH_CYCLES edges later; user_reset falls STAGGER_CYCLES edges after that.

Reset
REQ-029 reset=1 SHALL force: state=WAIT, cnt=0, porb sync chain=0, ext sync chain=1, ext_f=1, filter counter=0, rst_cause=00, ext_rst_count=0, por_done=0.
REQ-030 While in reset, outputs SHALL be core_resetb=0 and user_reset=1.
REQ-031 reset asserted mid-sequence SHALL abort the sequence and take effect at the next edge.

Verification
REQ-032 Defaults, ext_resetb=1, porb_l 0->1 at edge 0 -> core_resetb=1 at edge 19, user_reset=0 and por_done=1 at edge 27, rst_cause=00.
REQ-033 In RUN, ext_resetb low for 3 cycles -> no state change, ext_rst_count unchanged; low for 4 cycles -> ext_f=0 after 2+4 edges, WAIT, core_resetb=0, user_reset=1, rst_cause=10, ext_rst_count=1.
REQ-034 porb_l drops while in STRETCH at cnt=15 -> WAIT (not CORE) once porb_s=0, rst_cause=01, core_resetb stays 0.
REQ-035 porb_l and ext_resetb both drop in RUN together -> rst_cause=01 first (porb path faster), por_done stays 1; re-release follows REQ-028 timing.
REQ-036 300 accepted ext resets -> ext_rst_count=255; a synchronous reset in CORE -> all REQ-029 values next edge.

Source files
------------

// File: rtl/por_reset_sequencer.sv
// rtl/por_reset_sequencer.sv - power-on / pad reset sequencer with debounce, stretch and staggered release
module por_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STRETCH_CYCLES  = 16,
  parameter int STAGGER_CYCLES  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       porb_l,
  input  logic       ext_resetb,
  output logic       core_resetb,
  output logic       user_reset,
  output logic       por_done,
  output logic [1:0] rst_cause,
  output logic [7:0] ext_rst_count
);

  typedef enum logic [1:0] {S_WAIT, S_STRETCH, S_CORE, S_RUN} state_t;

  localparam logic [3:0] DEB_LAST     = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] STRETCH_LAST = 8'(STRETCH_CYCLES - 1);
  localparam logic [7:0] STAGGER_LAST = 8'(STAGGER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] porb_sync;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic                   porb_s;
  logic                   ext_s;
  logic                   ext_f;
  logic [3:0]             filt_cnt;
  logic                   ext_fall;
  logic                   ok;

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       load_cause;

  assign porb_s = porb_sync[SYNC_STAGES-1];
  assign ext_s  = ext_sync[SYNC_STAGES-1];
  assign ok     = porb_s & ext_f;

  always_ff @(posedge clock) begin
    if (reset) begin
      porb_sync <= '0;
      ext_sync  <= '1;
    end else begin
      porb_sync <= {porb_sync[SYNC_STAGES-2:0], porb_l};
      ext_sync  <= {ext_sync[SYNC_STAGES-2:0], ext_resetb};
    end
  end

  // Filter only flips after the synchronized pad value has disagreed for a full window.
  assign ext_fall = ext_f && !ext_s && (filt_cnt == DEB_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_f         <= 1'b1;
      filt_cnt      <= '0;
      ext_rst_count <= '0;
    end else begin
      if (ext_s != ext_f) begin
        if (filt_cnt == DEB_LAST) begin
          ext_f    <= ext_s;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
      if (ext_fall && (ext_rst_count != 8'hff)) begin
        ext_rst_count <= ext_rst_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_cause = 1'b0;
    case (state)
      S_WAIT: begin
        if (ok) begin
          state_next = S_STRETCH;
          cnt_next   = '0;
        end
      end
      S_STRETCH: begin
        if (!ok) begin
          state_next = S_WAIT;
          load_cause = 1'b1;
        end else if (cnt == STRETCH_LAST) begin
          state_next = S_CORE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      S_CORE: begin
        if (!ok) begin
          state_next = S_WAIT;
          load_cause = 1'b1;
        end else if (cnt == STAGGER_LAST) begin
          state_next = S_RUN;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: begin
        if (!ok) begin
          state_next = S_WAIT;
          load_cause = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_WAIT;
      cnt       <= '0;
      rst_cause <= 2'b00;
      por_done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load_cause) begin
        rst_cause <= {~ext_f, ~porb_s};
      end
      if (state_next == S_RUN) begin
        por_done <= 1'b1;
      end
    end
  end

  // Reset gating keeps both resets asserted even before the first edge of a reset pulse.
  assign core_resetb = !reset && ((state == S_CORE) || (state == S_RUN));
  assign user_reset  = reset || (state != S_RUN);

endmodule

// File: tb/tb_por_reset_sequencer.sv
// tb/tb_por_reset_sequencer.sv - randomized and directed checks of por_reset_sequencer against a run-length model
module tb_por_reset_sequencer;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int ST = 16;
  localparam int SG = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       porb_l = 1'b0;
  logic       ext_resetb = 1'b1;
  logic       core_resetb;
  logic       user_reset;
  logic       por_done;
  logic [1:0] rst_cause;
  logic [7:0] ext_rst_count;

  always #5 clock = ~clock;

  por_reset_sequencer #(
    .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .STRETCH_CYCLES(ST), .STAGGER_CYCLES(SG)
  ) dut (
    .clock(clock), .reset(reset), .porb_l(porb_l), .ext_resetb(ext_resetb),
    .core_resetb(core_resetb), .user_reset(user_reset), .por_done(por_done),
    .rst_cause(rst_cause), .ext_rst_count(ext_rst_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: delayed input views, filtered pad level, and the length of the current ok=1 run.
  bit         mvalid = 1'b0;
  bit         ph [SS];
  bit         xh [SS];
  bit         mf;
  int         mk;
  logic [1:0] mcause;
  bit         mdone;
  int         mcount;
  bit         dq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ps, xs, ok, flip;
    if (reset) begin
      foreach (ph[i]) ph[i] = 1'b0;
      foreach (xh[i]) xh[i] = 1'b1;
      mf = 1'b1; mk = 0; mcause = 2'b00; mdone = 1'b0; mcount = 0;
      dq.delete();
      mvalid = 1'b1;
    end else begin
      ps = ph[SS-1];
      xs = xh[SS-1];
      ok = ps & mf;
      if (!ok) begin
        if (mk > 0) mcause = {~mf, ~ps};
        mk = 0;
      end else if (mk < ST + SG + 1) begin
        mk++;
      end
      if (mk == ST + SG + 1) mdone = 1'b1;
      dq.push_back(xs);
      if (dq.size() > DB) void'(dq.pop_front());
      flip = (dq.size() == DB);
      foreach (dq[i]) if (dq[i] == mf) flip = 1'b0;
      if (flip) begin
        if (mf && mcount < 255) mcount++;
        mf = ~mf;
        dq.delete();
      end
      for (int i = SS - 1; i > 0; i--) begin
        ph[i] = ph[i-1];
        xh[i] = xh[i-1];
      end
      ph[0] = porb_l;
      xh[0] = ext_resetb;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    if (mvalid) begin
      chk("core_resetb", core_resetb, !reset && (mk > ST));
      chk("user_reset", user_reset, reset || (mk <= ST + SG));
      chk("por_done", por_done, mdone);
      chk("rst_cause", rst_cause, mcause);
      chk("ext_rst_count", ext_rst_count, mcount);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    run(3);
    chk("rst_core", core_resetb, 0);
    chk("rst_user", user_reset, 1);
    chk("rst_done", por_done, 0);
    chk("rst_cause0", rst_cause, 0);
    chk("rst_count0", ext_rst_count, 0);
    reset = 1'b0;
    run(4);

    // Nominal power-up release timing.
    porb_l = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      cycle();
      if (e == 18) chk("nom_core_e18", core_resetb, 0);
      if (e == 19) chk("nom_core_e19", core_resetb, 1);
      if (e == 26) chk("nom_user_e26", user_reset, 1);
      if (e == 27) begin
        chk("nom_user_e27", user_reset, 0);
        chk("nom_done_e27", por_done, 1);
        chk("nom_cause", rst_cause, 0);
      end
    end
    run(5);

    // Pad glitch of 3 cycles is filtered; 4 cycles is accepted.
    ext_resetb = 1'b0; run(3); ext_resetb = 1'b1; run(10);
    chk("glitch_count", ext_rst_count, 0);
    chk("glitch_user", user_reset, 0);
    ext_resetb = 1'b0; run(4); ext_resetb = 1'b1; run(2);
    chk("ext_count_e6", ext_rst_count, 1);
    cycle();
    chk("ext_core_e7", core_resetb, 0);
    chk("ext_user_e7", user_reset, 1);
    chk("ext_cause_e7", rst_cause, 2'b10);
    run(40);

    // Power drop landing exactly on the stretch terminal count.
    porb_l = 1'b0; run(5);
    porb_l = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      cycle();
      if (e == 16) porb_l = 1'b0;
      if (e == 19) begin
        chk("stretch_abort_core", core_resetb, 0);
        chk("stretch_abort_cause", rst_cause, 2'b01);
      end
    end
    porb_l = 1'b1; run(30);

    // Simultaneous loss of power and pad reset while running.
    porb_l = 1'b0; ext_resetb = 1'b0; run(3);
    chk("both_cause", rst_cause, 2'b01);
    chk("both_done", por_done, 1);
    chk("both_core", core_resetb, 0);
    run(7);
    chk("both_count", ext_rst_count, 2);
    porb_l = 1'b1; ext_resetb = 1'b1;
    for (int e = 1; e <= 23; e++) begin
      cycle();
      if (e == 22) chk("both_rel_e22", core_resetb, 0);
      if (e == 23) chk("both_rel_e23", core_resetb, 1);
    end
    run(10);

    // Counter saturation.
    for (int i = 0; i < 300; i++) begin
      ext_resetb = 1'b0; run(6);
      ext_resetb = 1'b1; run(6);
    end
    chk("count_sat", ext_rst_count, 255);
    run(10);

    // Synchronous reset in CORE, then release with power already good.
    porb_l = 1'b0; run(5);
    porb_l = 1'b1; run(20);
    chk("pre_rst_core", core_resetb, 1);
    chk("pre_rst_user", user_reset, 1);
    reset = 1'b1;
    cycle();
    chk("mid_rst_core", core_resetb, 0);
    chk("mid_rst_user", user_reset, 1);
    chk("mid_rst_done", por_done, 0);
    chk("mid_rst_cause", rst_cause, 0);
    chk("mid_rst_count", ext_rst_count, 0);
    run(2);
    reset = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      cycle();
      if (e == 18) chk("post_rst_e18", core_resetb, 0);
      if (e == 19) chk("post_rst_e19", core_resetb, 1);
    end

    // Random segments of power, pad and occasional reset activity.
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 30) == 0) begin
        reset = 1'b1;
        run($urandom_range(1, 3));
        reset = 1'b0;
      end
      porb_l     = ($urandom_range(0, 9) != 0);
      ext_resetb = ($urandom_range(0, 5) != 0);
      run($urandom_range(1, 40));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
